// File: rtl/remote_cmd_link_if.sv
// Host-side link signals: serial pins, command strobe/status and response byte.
// Debug fields expose the command and receive FSM states for checkers.
interface remote_cmd_link_if;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic [1:0]  cmd_state_dbg;
  logic [1:0]  rx_state_dbg;

  modport slave (
    input  RX, cmd, snd_cmd,
    output TX, cmd_snt, resp_rdy, resp, cmd_state_dbg, rx_state_dbg
  );

  modport master (
    output RX, cmd, snd_cmd,
    input  TX, cmd_snt, resp_rdy, resp, cmd_state_dbg, rx_state_dbg
  );
endinterface

// File: rtl/remote_cmd_link.sv
// Knight's Tour host command link: sends a 16-bit command as two 8N1 bytes
// (high byte first) and receives 8-bit response bytes on an independent UART RX.
module remote_cmd_link #(
  parameter int BAUD_DIV = 2604
) (
  input  logic               clk,
  input  logic               rst_n,
  remote_cmd_link_if.slave   link
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_TICK = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_HIGH = 2'd1, C_LOW = 2'd2} cmd_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_RECV = 2'd1} rx_state_t;

  // Handshake: snd_cmd is a one-cycle valid that is only accepted (implicitly
  // ready) in C_IDLE; cmd_snt is a completion level held until the next accept.

  cmd_state_t      cmd_state, cmd_next;
  logic            load_high, load_low, set_snt;
  logic [9:0]      tx_shift;
  logic [CW-1:0]   tx_baud_cnt;
  logic [3:0]      tx_bit_cnt;
  logic [7:0]      cmd_lo;
  logic            cmd_snt_q;
  logic            baud_done, frame_done;

  assign baud_done  = (tx_baud_cnt == FULL_TICK);
  assign frame_done = baud_done && (tx_bit_cnt == 4'd9);

  always_ff @(posedge clk) begin
    if (rst_n) cmd_state <= C_IDLE;
    else       cmd_state <= cmd_next;
  end

  always_comb begin
    cmd_next  = cmd_state;
    load_high = 1'b0;
    load_low  = 1'b0;
    set_snt   = 1'b0;
    case (cmd_state)
      C_IDLE: if (link.snd_cmd) begin
        load_high = 1'b1;
        cmd_next  = C_HIGH;
      end
      C_HIGH: if (frame_done) begin
        load_low = 1'b1;
        cmd_next = C_LOW;
      end
      C_LOW: if (frame_done) begin
        set_snt  = 1'b1;
        cmd_next = C_IDLE;
      end
      default: cmd_next = C_IDLE;
    endcase
  end

  // The frame register shifts ones in behind the stop bit, so TX idles high.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_shift    <= '1;
      tx_baud_cnt <= '0;
      tx_bit_cnt  <= '0;
      cmd_lo      <= '0;
      cmd_snt_q   <= 1'b0;
    end else begin
      if (load_high) begin
        cmd_lo      <= link.cmd[7:0];
        tx_shift    <= {1'b1, link.cmd[15:8], 1'b0};
        tx_baud_cnt <= '0;
        tx_bit_cnt  <= '0;
        cmd_snt_q   <= 1'b0;
      end else if (load_low) begin
        tx_shift    <= {1'b1, cmd_lo, 1'b0};
        tx_baud_cnt <= '0;
        tx_bit_cnt  <= '0;
      end else if (cmd_state != C_IDLE) begin
        if (baud_done) begin
          tx_baud_cnt <= '0;
          tx_bit_cnt  <= tx_bit_cnt + 4'd1;
          tx_shift    <= {1'b1, tx_shift[9:1]};
        end else begin
          tx_baud_cnt <= tx_baud_cnt + 1'b1;
        end
      end
      if (set_snt) cmd_snt_q <= 1'b1;
    end
  end

  rx_state_t       rx_state, rx_next;
  logic            rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]   rx_cnt;
  logic [9:0]      rx_shift;
  logic            rx_first, rx_tick;
  logic            rx_start, rx_sample, rx_done;
  logic [7:0]      resp_q;
  logic            resp_rdy_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= link.RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // rx_shift is preloaded with ones; the start bit reaching bit 0 marks a full frame.
  assign rx_first = (rx_shift == 10'h3FF);
  assign rx_tick  = (rx_cnt == (rx_first ? HALF_TICK : FULL_TICK));

  always_ff @(posedge clk) begin
    if (rst_n) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next   = rx_state;
    rx_start  = 1'b0;
    rx_sample = 1'b0;
    rx_done   = 1'b0;
    case (rx_state)
      R_IDLE: if (rx_prev && !rx_s2) begin
        rx_start = 1'b1;
        rx_next  = R_RECV;
      end
      R_RECV: begin
        if (!rx_shift[0]) begin
          rx_done = 1'b1;
          rx_next = R_IDLE;
        end else if (rx_tick) begin
          if (rx_first && rx_s2) rx_next = R_IDLE;
          else                   rx_sample = 1'b1;
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_cnt     <= '0;
      rx_shift   <= '1;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      if (rx_start) begin
        rx_cnt   <= '0;
        rx_shift <= '1;
      end else if (rx_state == R_RECV) begin
        if (rx_tick) rx_cnt <= '0;
        else         rx_cnt <= rx_cnt + 1'b1;
      end
      if (rx_sample) rx_shift <= {rx_s2, rx_shift[9:1]};
      if (rx_done)   resp_q   <= rx_shift[8:1];
      if (load_high || rx_start) resp_rdy_q <= 1'b0;
      if (rx_done)               resp_rdy_q <= 1'b1;
    end
  end

  assign link.TX            = tx_shift[0];
  assign link.cmd_snt       = cmd_snt_q;
  assign link.resp          = resp_q;
  assign link.resp_rdy      = resp_rdy_q;
  assign link.cmd_state_dbg = cmd_state;
  assign link.rx_state_dbg  = rx_state;

endmodule

// File: tb/tb_remote_cmd_link.sv
// Directed bench for remote_cmd_link: command serialization, response reception,
// ignored strobes, RX glitch rejection and mid-frame reset.
module tb_remote_cmd_link;

  localparam int B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   t0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  remote_cmd_link_if link();

  remote_cmd_link #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic pulse_cmd(input logic [15:0] c);
    @(negedge clk);
    link.cmd     = c;
    link.snd_cmd = 1'b1;
    @(negedge clk);
    link.snd_cmd = 1'b0;
    t0 = cyc;
  endtask

  task automatic capture_byte(output logic [7:0] b, output logic ok, output int start_cyc);
    int n;
    logic [9:0] f;
    b = '0; ok = 1'b0; start_cyc = -1; n = 0; f = '0;
    while (link.TX !== 1'b0 && n < 12 * B) begin
      @(negedge clk);
      n++;
    end
    if (link.TX !== 1'b0) return;
    start_cyc = cyc;
    repeat (B / 2) @(negedge clk);
    f[0] = link.TX;
    for (int i = 1; i < 10; i++) begin
      repeat (B) @(negedge clk);
      f[i] = link.TX;
    end
    b  = f[8:1];
    ok = (f[0] == 1'b0) && (f[9] == 1'b1);
  endtask

  task automatic wait_cmd_snt(output int lat);
    int n;
    n = 0;
    while (link.cmd_snt !== 1'b1 && n < 25 * B) begin
      @(negedge clk);
      n++;
    end
    lat = (link.cmd_snt === 1'b1) ? (cyc - t0) : -1;
  endtask

  task automatic uart_send_rx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      link.RX = f[i];
      repeat (B) @(negedge clk);
    end
    link.RX = 1'b1;
  endtask

  task automatic idle_watch(input int cycles, output int tx_low, output int snt_high);
    tx_low = 0; snt_high = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (link.TX !== 1'b1)      tx_low++;
      if (link.cmd_snt !== 1'b0) snt_high++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    link.RX = 1'b1; link.cmd = '0; link.snd_cmd = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (link.TX !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b exp 1", link.TX); end
    n_tests++; if (link.cmd_snt !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_snt got %b exp 0", link.cmd_snt); end
    n_tests++; if (link.resp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_resp_rdy got %b exp 0", link.resp_rdy); end
    n_tests++; if (link.resp !== 8'h00) begin n_fail++; $display("FAIL reset_resp got %h exp 00", link.resp); end
  endtask

  task automatic test_send();
    logic [7:0] hi, lo;
    logic ok_hi, ok_lo;
    int s_hi, s_lo, lat, tl, sh;
    pulse_cmd(16'h4002);
    link.cmd = 16'hFFFF;  // must not disturb the latched command
    n_tests++; if (link.TX !== 1'b0) begin n_fail++; $display("FAIL send_start_bit got %b exp 0", link.TX); end
    capture_byte(hi, ok_hi, s_hi);
    capture_byte(lo, ok_lo, s_lo);
    n_tests++; if (hi !== 8'h40 || ok_hi !== 1'b1) begin n_fail++; $display("FAIL send_hi_byte got %h ok=%b exp 40 ok=1", hi, ok_hi); end
    n_tests++; if (lo !== 8'h02 || ok_lo !== 1'b1) begin n_fail++; $display("FAIL send_lo_byte got %h ok=%b exp 02 ok=1", lo, ok_lo); end
    n_tests++; if (s_lo - s_hi < 10 * B || s_lo - s_hi > 10 * B + 2) begin
      n_fail++; $display("FAIL send_gap got %0d exp %0d..%0d", s_lo - s_hi, 10 * B, 10 * B + 2); end
    wait_cmd_snt(lat);
    n_tests++; if (lat < 20 * B - 4 || lat > 20 * B + 4) begin
      n_fail++; $display("FAIL send_latency got %0d exp %0d+-4", lat, 20 * B); end
    idle_watch(3 * B, tl, sh);
    n_tests++; if (sh != 3 * B) begin n_fail++; $display("FAIL send_cmd_snt_level got %0d high cycles exp %0d", sh, 3 * B); end
    n_tests++; if (tl != 0) begin n_fail++; $display("FAIL send_tx_idle got %0d low cycles exp 0", tl); end
  endtask

  task automatic test_echo();
    int n;
    n = 0;
    fork
      uart_send_rx(8'hA5);
      begin
        @(negedge clk);
        while (link.resp_rdy !== 1'b1 && n < 12 * B) begin
          @(negedge clk);
          n++;
        end
      end
    join
    n_tests++; if (n < B * 19 / 2 || n > B * 19 / 2 + 5) begin
      n_fail++; $display("FAIL echo_rdy_time got %0d exp %0d..%0d", n, B * 19 / 2, B * 19 / 2 + 5); end
    n_tests++; if (link.resp !== 8'hA5) begin n_fail++; $display("FAIL echo_resp got %h exp a5", link.resp); end
    repeat (2 * B) @(negedge clk);
    n_tests++; if (link.resp_rdy !== 1'b1) begin n_fail++; $display("FAIL echo_rdy_level got %b exp 1", link.resp_rdy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] hi, lo;
    logic ok_hi, ok_lo;
    int s_hi, s_lo, lat, tl, sh;
    pulse_cmd(16'h5BF1);
    n_tests++; if (link.resp_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_clear got %b exp 0", link.resp_rdy); end
    n_tests++; if (link.cmd_snt !== 1'b0) begin n_fail++; $display("FAIL b2b_snt_clear got %b exp 0", link.cmd_snt); end
    fork
      begin
        capture_byte(hi, ok_hi, s_hi);
        capture_byte(lo, ok_lo, s_lo);
      end
      begin
        repeat (3 * B) @(negedge clk);
        link.cmd     = 16'h47F1;
        link.snd_cmd = 1'b1;
        @(negedge clk);
        link.snd_cmd = 1'b0;
      end
    join
    n_tests++; if (hi !== 8'h5B || ok_hi !== 1'b1) begin n_fail++; $display("FAIL b2b_first_hi got %h ok=%b exp 5b ok=1", hi, ok_hi); end
    n_tests++; if (lo !== 8'hF1 || ok_lo !== 1'b1) begin n_fail++; $display("FAIL b2b_first_lo got %h ok=%b exp f1 ok=1", lo, ok_lo); end
    wait_cmd_snt(lat);
    n_tests++; if (lat < 20 * B - 4 || lat > 20 * B + 4) begin
      n_fail++; $display("FAIL b2b_latency got %0d exp %0d+-4", lat, 20 * B); end
    idle_watch(12 * B, tl, sh);
    n_tests++; if (tl != 0) begin n_fail++; $display("FAIL b2b_no_extra_frame got %0d low cycles exp 0", tl); end
    pulse_cmd(16'h47F1);
    capture_byte(hi, ok_hi, s_hi);
    capture_byte(lo, ok_lo, s_lo);
    n_tests++; if (hi !== 8'h47 || ok_hi !== 1'b1) begin n_fail++; $display("FAIL b2b_second_hi got %h ok=%b exp 47 ok=1", hi, ok_hi); end
    n_tests++; if (lo !== 8'hF1 || ok_lo !== 1'b1) begin n_fail++; $display("FAIL b2b_second_lo got %h ok=%b exp f1 ok=1", lo, ok_lo); end
    wait_cmd_snt(lat);
    n_tests++; if (lat < 0) begin n_fail++; $display("FAIL b2b_second_snt got timeout exp cmd_snt=1"); end
  endtask

  task automatic test_rx_glitch();
    int rdy_cnt;
    rdy_cnt = 0;
    @(negedge clk);
    link.RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    link.RX = 1'b1;
    repeat (12 * B) begin
      @(negedge clk);
      if (link.resp_rdy !== 1'b0) rdy_cnt++;
    end
    n_tests++; if (rdy_cnt != 0) begin n_fail++; $display("FAIL glitch_no_rdy got %0d cycles exp 0", rdy_cnt); end
    n_tests++; if (link.resp !== 8'hA5) begin n_fail++; $display("FAIL glitch_resp_hold got %h exp a5", link.resp); end
    uart_send_rx(8'h5A);
    repeat (4) @(negedge clk);
    n_tests++; if (link.resp !== 8'h5A) begin n_fail++; $display("FAIL glitch_valid_resp got %h exp 5a", link.resp); end
    n_tests++; if (link.resp_rdy !== 1'b1) begin n_fail++; $display("FAIL glitch_valid_rdy got %b exp 1", link.resp_rdy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] hi, lo;
    logic ok_hi, ok_lo;
    int s_hi, s_lo, lat, tl, sh;
    pulse_cmd(16'h53F2);
    repeat (3 * B) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    n_tests++; if (link.TX !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx got %b exp 1", link.TX); end
    n_tests++; if (link.cmd_snt !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_snt got %b exp 0", link.cmd_snt); end
    n_tests++; if (link.resp !== 8'h00 || link.resp_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_resp got %h rdy=%b exp 00 rdy=0", link.resp, link.resp_rdy); end
    idle_watch(24 * B, tl, sh);
    n_tests++; if (tl != 0 || sh != 0) begin
      n_fail++; $display("FAIL rstmid_aborted got tx_low=%0d snt_high=%0d exp 0 0", tl, sh); end
    pulse_cmd(16'h53F2);
    capture_byte(hi, ok_hi, s_hi);
    capture_byte(lo, ok_lo, s_lo);
    n_tests++; if (hi !== 8'h53 || ok_hi !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_hi got %h ok=%b exp 53 ok=1", hi, ok_hi); end
    n_tests++; if (lo !== 8'hF2 || ok_lo !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_lo got %h ok=%b exp f2 ok=1", lo, ok_lo); end
    wait_cmd_snt(lat);
    n_tests++; if (lat < 20 * B - 4 || lat > 20 * B + 4) begin
      n_fail++; $display("FAIL rstmid_fresh_latency got %0d exp %0d+-4", lat, 20 * B); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_send();
    test_echo();
    test_back_to_back();
    test_rx_glitch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
